// File: rtl/alu_arbiter_if.sv
// Requester, ALU-side and response signals of alu_arbiter bundled into one interface.
// The slave modport is the arbiter's view; master is the fabric/ALU/consumer side.
interface alu_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*4-1:0] req_a;
  logic [NUM_REQ*4-1:0] req_b;
  logic [NUM_REQ*2-1:0] req_op;
  logic [3:0]           alu_a;
  logic [3:0]           alu_b;
  logic [1:0]           alu_opcode;
  logic [4:0]           alu_c;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [4:0]           rsp_data;
  logic [ID_W-1:0]      rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_c, rsp_ready,
    output req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_c, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered 4-bit ALU among NUM_REQ requesters.
// Define ALU_ARBITER_STATS_EN to add the op_count and busy outputs.
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef ALU_ARBITER_STATS_EN
  output logic [15:0]  op_count,
  output logic         busy,
`endif
  alu_arbiter_if.slave bus
);
  localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] CAPT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    winner_inc;
  logic [LAT_W-1:0]   lat_cnt;
  logic [NUM_REQ-1:0] rot;
  logic               found;
  logic               accept;
  logic [3:0]         sel_a;
  logic [3:0]         sel_b;
  logic [1:0]         sel_op;
  int unsigned        off;
  int unsigned        sum;

  // Rotate valids so bit 0 is the requester at rr_ptr, then take the lowest set bit.
  always_comb begin
    rot   = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
    found = |rot;
    off   = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    sum = 32'(rr_ptr) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    winner     = ID_W'(sum);
    winner_inc = (sum == NUM_REQ - 1) ? '0 : ID_W'(sum + 1);
    accept     = (state == IDLE) && found;
  end

  // Winner's operands and the one-hot combinational accept.
  always_comb begin
    sel_a         = '0;
    sel_b         = '0;
    sel_op        = '0;
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_a            = bus.req_a[4*i +: 4];
        sel_b            = bus.req_b[4*i +: 4];
        sel_op           = bus.req_op[2*i +: 2];
        bus.req_ready[i] = accept;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    if (lat_cnt == '0) state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand issue, latency count and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      lat_cnt        <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_opcode <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            bus.alu_a      <= sel_a;
            bus.alu_b      <= sel_b;
            bus.alu_opcode <= sel_op;
            bus.rsp_id     <= winner;
            rr_ptr         <= winner_inc;
            lat_cnt        <= LAT_W'(ALU_LAT - 1);
          end
        end
        EXEC: if (lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
        CAPT: begin
          bus.rsp_data  <= bus.alu_c;
          bus.rsp_valid <= 1'b1;
        end
        RESP: if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  // Saturating response counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
      busy     <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      if ((state == RESP) && bus.rsp_ready && (op_count != 16'hFFFF))
        op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: ALU_LAT=1 and ALU_LAT=3 instances, vector table,
// directed corner sequences and a randomized run against a transaction-level model.
module tb_alu_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  alu_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) if1 ();
  alu_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) if3 ();

`ifdef ALU_ARBITER_STATS_EN
  logic [15:0] cnt1, cnt3;
  logic        busy1, busy3;
`endif

  alu_arbiter #(.NUM_REQ(N), .ID_W(IW), .ALU_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
`ifdef ALU_ARBITER_STATS_EN
    .op_count(cnt1), .busy(busy1),
`endif
    .bus(if1.slave));

  alu_arbiter #(.NUM_REQ(N), .ID_W(IW), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
`ifdef ALU_ARBITER_STATS_EN
    .op_count(cnt3), .busy(busy3),
`endif
    .bus(if3.slave));

  // Arithmetic meaning of each opcode on signed 4-bit operands.
  function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'b00:   r = sa + sb;
      2'b01:   r = sa - sb;
      2'b10:   r = -sa - 1;
      default: r = (b != 4'd0) ? 1 : 0;
    endcase
    return 5'(r);
  endfunction

  // External ALUs: one register stage, and a three-stage pipeline.
  logic [4:0] c1;
  logic [4:0] p3 [3];
  always_ff @(posedge clk) begin
    c1    <= alu_ref(if1.alu_a, if1.alu_b, if1.alu_opcode);
    p3[0] <= alu_ref(if3.alu_a, if3.alu_b, if3.alu_opcode);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign if1.alu_c = c1;
  assign if3.alu_c = p3[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic [N-1:0] v, input logic [N*4-1:0] a,
                       input logic [N*4-1:0] b, input logic [N*2-1:0] op, input logic rr);
    if (d == 1) begin
      if1.req_valid = v; if1.req_a = a; if1.req_b = b; if1.req_op = op; if1.rsp_ready = rr;
    end else begin
      if3.req_valid = v; if3.req_a = a; if3.req_b = b; if3.req_op = op; if3.rsp_ready = rr;
    end
  endtask

  function automatic logic [N-1:0] rdy(input int d);
    return (d == 1) ? if1.req_ready : if3.req_ready;
  endfunction
  function automatic logic rv(input int d);
    return (d == 1) ? if1.rsp_valid : if3.rsp_valid;
  endfunction
  function automatic logic [4:0] rd(input int d);
    return (d == 1) ? if1.rsp_data : if3.rsp_data;
  endfunction
  function automatic logic [IW-1:0] rid(input int d);
    return (d == 1) ? if1.rsp_id : if3.rsp_id;
  endfunction
  function automatic logic [9:0] alui(input int d);
    return (d == 1) ? {if1.alu_a, if1.alu_b, if1.alu_opcode}
                    : {if3.alu_a, if3.alu_b, if3.alu_opcode};
  endfunction

  // Called at a negedge with rsp_ready=1; returns at the negedge after the handshake.
  task automatic wait_rsp(input int d, input logic [4:0] ed, input int eid, input string tag);
    int n;
    n = 0;
    while (!rv(d) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s rsp_valid", tag), 32'(rv(d)), 1);
    chk($sformatf("%s rsp_data", tag), 32'(rd(d)), 32'(ed));
    chk($sformatf("%s rsp_id", tag), 32'(rid(d)), eid);
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; leaves at the negedge after the response handshake.
  task automatic single_op(input int d, input int req, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op, input logic [4:0] ed, input string tag);
    int lat;
    logic [N-1:0] oh;
    oh = N'(1) << req;
    drive(d, oh, (N*4)'(a) << (4*req), (N*4)'(b) << (4*req), (N*2)'(op) << (2*req), 1'b1);
    #1 chk($sformatf("%s ready", tag), 32'(rdy(d)), 32'(oh));
    @(negedge clk);
    drive(d, '0, '0, '0, '0, 1'b1);
    lat = 1;
    while (!rv(d) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("%s latency", tag), lat, d + 2);
    chk($sformatf("%s data", tag), 32'(rd(d)), 32'(ed));
    chk($sformatf("%s id", tag), 32'(rid(d)), req);
    chk($sformatf("%s alu inputs", tag), 32'(alui(d)), 32'({a, b, op}));
    @(negedge clk);
    chk($sformatf("%s rsp_valid drop", tag), 32'(rv(d)), 0);
  endtask

  // Transaction-level model: one op outstanding, result ALU_LAT+2 cycles after accept,
  // grants scanned round-robin from the requester after the previous winner.
  task automatic run_random(input int ncyc, output int nrsp);
    logic [N-1:0]   v, eready;
    logic [N*4-1:0] av, bv;
    logic [N*2-1:0] ov;
    logic           rr, mbusy, exp_rv;
    logic [4:0]     edata;
    int ptr, since, eid, win, j;
    v = '0; av = '0; bv = '0; ov = '0;
    mbusy = 1'b0; since = 0; ptr = 0; eid = 0; edata = '0; nrsp = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!v[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            v[i] = 1'b1;
            av[4*i +: 4] = 4'($urandom);
            bv[4*i +: 4] = 4'($urandom);
            ov[2*i +: 2] = 2'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          v[i] = 1'b0;
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      drive(1, v, av, bv, ov, rr);
      #1;
      win = -1;
      if (!mbusy) begin
        for (int k = 0; k < N; k++) begin
          j = (ptr + k) % N;
          if (win < 0 && v[j]) win = j;
        end
      end
      eready = (win >= 0) ? (N'(1) << win) : '0;
      exp_rv = mbusy && (since >= 3);
      chk("rand ready", 32'(rdy(1)), 32'(eready));
      chk("rand rsp_valid", 32'(rv(1)), 32'(exp_rv));
      if (exp_rv) begin
        chk("rand rsp_data", 32'(rd(1)), 32'(edata));
        chk("rand rsp_id", 32'(rid(1)), eid);
      end
`ifdef ALU_ARBITER_STATS_EN
      chk("rand busy", 32'(busy1), 32'(mbusy));
`endif
      if (exp_rv && rr) begin
        mbusy = 1'b0;
        nrsp++;
      end else if (mbusy) begin
        since++;
      end
      if (win >= 0) begin
        mbusy = 1'b1;
        since = 1;
        eid   = win;
        edata = alu_ref(av[4*win +: 4], bv[4*win +: 4], ov[2*win +: 2]);
        ptr   = (win + 1) % N;
        v[win] = 1'b0;
      end
    end
  endtask

  typedef struct {
    int         d;
    int         req;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    int ng, last, cyc, nrsp, gid;

    tbl[0]  = '{1, 0, 4'd3,    4'd4,    2'b00, 5'b00111};
    tbl[1]  = '{1, 1, 4'd2,    4'd5,    2'b01, 5'b11101};
    tbl[2]  = '{1, 1, 4'd5,    4'd5,    2'b10, 5'b11010};
    tbl[3]  = '{1, 2, 4'b1000, 4'b1000, 2'b00, 5'b10000};
    tbl[4]  = '{1, 3, 4'd7,    4'd7,    2'b00, 5'b01110};
    tbl[5]  = '{1, 0, 4'b1000, 4'd7,    2'b01, 5'b10001};
    tbl[6]  = '{1, 2, 4'd7,    4'b1000, 2'b01, 5'b01111};
    tbl[7]  = '{1, 3, 4'b1111, 4'd0,    2'b10, 5'b00000};
    tbl[8]  = '{1, 1, 4'b1010, 4'd3,    2'b11, 5'b00001};
    tbl[9]  = '{3, 0, 4'd0,    4'd0,    2'b11, 5'b00000};
    tbl[10] = '{3, 0, 4'd0,    4'b1000, 2'b11, 5'b00001};
    tbl[11] = '{3, 2, 4'd3,    4'b1110, 2'b00, 5'b00001};

    drive(1, '0, '0, '0, '0, 1'b1);
    drive(3, '0, '0, '0, '0, 1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 1; d <= 3; d += 2) begin
      chk($sformatf("reset%0d ready", d), 32'(rdy(d)), 0);
      chk($sformatf("reset%0d rsp_valid", d), 32'(rv(d)), 0);
      chk($sformatf("reset%0d rsp_data", d), 32'(rd(d)), 0);
      chk($sformatf("reset%0d rsp_id", d), 32'(rid(d)), 0);
      chk($sformatf("reset%0d alu inputs", d), 32'(alui(d)), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 12; t++)
      single_op(tbl[t].d, tbl[t].req, tbl[t].a, tbl[t].b, tbl[t].op, tbl[t].exp,
                $sformatf("vec%0d", t));

    // All requesters valid from reset: grants 0,1,2,3,0 spaced four cycles apart.
    rst = 1'b1;
    drive(1, 4'hF, 16'h3210, 16'h1111, 8'h00, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    ng = 0; last = -1; cyc = 0; gid = 0;
    while (ng < 5 && cyc < 60) begin
      #1;
      r = rdy(1);
      if (rv(1)) begin
        chk("rr rsp_id", 32'(rid(1)), gid);
        chk("rr rsp_data", 32'(rd(1)), gid + 1);
      end
      if (r != '0) begin
        chk("rr onehot", 32'($onehot(r)), 1);
        chk($sformatf("rr grant %0d", ng), $clog2(r), ng % N);
        if (last >= 0) chk("rr spacing", cyc - last, 4);
        gid = $clog2(r);
        last = cyc;
        ng++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("rr grant count", ng, 5);
    drive(1, '0, '0, '0, '0, 1'b1);
    repeat (8) @(negedge clk);

    // Backpressure: response held ten cycles, req3 waits with ready low.
    drive(1, 4'b0001, 16'h000D, 16'h0002, 8'h00, 1'b0);
    @(negedge clk);
    drive(1, 4'b1000, 16'h1000, 16'h1000, 8'h00, 1'b0);
    cyc = 0;
    while (!rv(1) && cyc < 20) begin
      #1 chk("bp ready while busy", 32'(rdy(1)), 0);
      @(negedge clk);
      cyc++;
    end
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp rsp_valid", 32'(rv(1)), 1);
      chk("bp rsp_data", 32'(rd(1)), 32'(5'b11111));
      chk("bp rsp_id", 32'(rid(1)), 0);
      chk("bp ready", 32'(rdy(1)), 0);
      @(negedge clk);
    end
    drive(1, 4'b1000, 16'h1000, 16'h1000, 8'h00, 1'b1);
    @(negedge clk);
    chk("bp release", 32'(rv(1)), 0);
    #1 chk("bp next grant", 32'(rdy(1)), 32'(4'b1000));
    @(negedge clk);
    drive(1, '0, '0, '0, '0, 1'b1);
    wait_rsp(1, 5'd2, 3, "bp req3");

    // Reset while EXEC: op abandoned, pointer back to 0.
    drive(1, 4'b0010, 16'h0010, 16'h0010, 8'h00, 1'b1);
    @(negedge clk);
    drive(1, '0, '0, '0, '0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst-op rsp_valid", 32'(rv(1)), 0);
    chk("rst-op alu inputs", 32'(alui(1)), 0);
    chk("rst-op rsp_id", 32'(rid(1)), 0);
    chk("rst-op rsp_data", 32'(rd(1)), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst-op no orphan rsp", 32'(rv(1)), 0);
    end
    drive(1, 4'b0110, 16'h0210, 16'h0110, 8'h00, 1'b1);
    #1 chk("rst-op grant from ptr 0", 32'(rdy(1)), 32'(4'b0010));
    @(negedge clk);
    drive(1, 4'b0100, 16'h0210, 16'h0110, 8'h00, 1'b1);
    wait_rsp(1, 5'd2, 1, "rst-op req1");
    #1 chk("rst-op req2 grant", 32'(rdy(1)), 32'(4'b0100));
    @(negedge clk);
    drive(1, '0, '0, '0, '0, 1'b1);
    wait_rsp(1, 5'd3, 2, "rst-op req2");

    // Randomized traffic against the transaction-level model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_random(1500, nrsp);
    chk("rand responses seen", 32'(nrsp > 50), 1);
`ifdef ALU_ARBITER_STATS_EN
    chk("op_count", 32'(cnt1), nrsp);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
